// File: rtl/jam_pkg.sv
// Shared sizing, types and FSM encoding for the JAM cost-table responder.
package jam_pkg;
    localparam int N_W    = 8;
    localparam int N_J    = 8;
    localparam int COST_W = 7;
    localparam int MINC_W = 10;
    localparam int CNT_W  = 24;
    localparam int N_ENT  = N_W * N_J;
    localparam int IDX_W  = $clog2(N_ENT);
    localparam int WA_W   = $clog2(N_W);
    localparam int JA_W   = $clog2(N_J);

    typedef logic [COST_W-1:0] cost_t;

    typedef enum logic [1:0] {S_LOAD, S_SERVE, S_DONE} srv_state_e;
endpackage

// File: rtl/jam_cost_ram.sv
// 64-entry cost table: synchronous write, registered lookup address, combinational read.
module jam_cost_ram
    import jam_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  cost_t            i_wdata,
    input  logic             i_track,
    input  logic [WA_W-1:0]  i_w,
    input  logic [JA_W-1:0]  i_j,
    output cost_t            o_cost
);
    cost_t           r_mem [N_ENT];
    logic [WA_W-1:0] r_w_s;
    logic [JA_W-1:0] r_j_s;

    always_ff @(posedge CLK) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_w_s <= '0;
            r_j_s <= '0;
        end else if (i_track) begin
            r_w_s <= i_w;
            r_j_s <= i_j;
        end
    end

    // N_J is a power of two, so {W,J} is exactly the row-major index W*N_J+J.
    assign o_cost = r_mem[{r_w_s, r_j_s}];
endmodule

// File: rtl/jam_cost_server.sv
// Responder beside JAM: loads the cost table, serves W/J lookups and checks JAM's result.
module jam_cost_server
    import jam_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              load_valid,
    input  cost_t             load_data,
    output logic              load_ready,
    input  logic              gold_we,
    input  logic [MINC_W-1:0] gold_min_cost,
    input  logic [3:0]        gold_match_cnt,
    input  logic [WA_W-1:0]   W,
    input  logic [JA_W-1:0]   J,
    output cost_t             Cost,
    input  logic [MINC_W-1:0] MinCost,
    input  logic [3:0]        MatchCount,
    input  logic              Valid,
    output logic              table_ready,
    output logic              done,
    output logic              pass,
    output logic              proto_err,
    output logic [CNT_W-1:0]  lookup_cnt
);
    srv_state_e        r_state, w_state_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic [MINC_W-1:0] r_gold_min;
    logic [3:0]        r_gold_cnt;
    logic              r_done, r_pass, r_proto_err;
    logic [CNT_W-1:0]  r_lookup_cnt;
    logic              w_accept;
    logic              w_match;
    cost_t             w_cost;

    assign w_accept = load_valid && (r_state == S_LOAD);
    assign w_match  = (MinCost == r_gold_min) && (MatchCount == r_gold_cnt);

    always_ff @(posedge CLK) begin
        if (RST)
            r_state <= S_LOAD;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LOAD:  if (w_accept && (r_idx == IDX_W'(N_ENT - 1))) w_state_nxt = S_SERVE;
            S_SERVE: if (Valid) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_DONE;
            default: w_state_nxt = S_LOAD;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_idx        <= '0;
            r_gold_min   <= '0;
            r_gold_cnt   <= '0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_proto_err  <= 1'b0;
            r_lookup_cnt <= '0;
        end else begin
            if (w_accept)
                r_idx <= r_idx + 1'b1;
            // Golden values freeze once the result is captured; a same-edge write loses to the compare.
            if (gold_we && (r_state != S_DONE)) begin
                r_gold_min <= gold_min_cost;
                r_gold_cnt <= gold_match_cnt;
            end
            if ((r_state == S_LOAD) && Valid)
                r_proto_err <= 1'b1;
            if (r_state == S_SERVE) begin
                if (r_lookup_cnt != '1)
                    r_lookup_cnt <= r_lookup_cnt + 1'b1;
                if (Valid) begin
                    r_done <= 1'b1;
                    r_pass <= w_match;
                end
            end
        end
    end

    jam_cost_ram u_ram (
        .CLK     (CLK),
        .RST     (RST),
        .i_we    (w_accept),
        .i_waddr (r_idx),
        .i_wdata (load_data),
        .i_track (r_state != S_LOAD),
        .i_w     (W),
        .i_j     (J),
        .o_cost  (w_cost)
    );

    assign load_ready  = (r_state == S_LOAD);
    assign table_ready = (r_state != S_LOAD);
    assign Cost        = (r_state == S_LOAD) ? '0 : w_cost;
    assign done        = r_done;
    assign pass        = r_pass;
    assign proto_err   = r_proto_err;
    assign lookup_cnt  = r_lookup_cnt;
endmodule

// File: tb/tb_jam_cost_server.sv
// Scoreboard bench for jam_cost_server: stimulus queues expectations per cycle, a monitor checks them.
module tb_jam_cost_server;
    import jam_pkg::*;

    localparam int SEL_COST = 0, SEL_TRDY = 1, SEL_LRDY = 2, SEL_DONE = 3,
                   SEL_PASS = 4, SEL_PERR = 5, SEL_LCNT = 6;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic              CLK = 1'b0;
    logic              RST;
    logic              load_valid;
    cost_t             load_data;
    logic              load_ready;
    logic              gold_we;
    logic [MINC_W-1:0] gold_min_cost;
    logic [3:0]        gold_match_cnt;
    logic [WA_W-1:0]   W;
    logic [JA_W-1:0]   J;
    cost_t             Cost;
    logic [MINC_W-1:0] MinCost;
    logic [3:0]        MatchCount;
    logic              Valid;
    logic              table_ready, done, pass, proto_err;
    logic [CNT_W-1:0]  lookup_cnt;

    exp_t q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    jam_cost_server dut (
        .CLK(CLK), .RST(RST), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .gold_we(gold_we), .gold_min_cost(gold_min_cost),
        .gold_match_cnt(gold_match_cnt), .W(W), .J(J), .Cost(Cost), .MinCost(MinCost),
        .MatchCount(MatchCount), .Valid(Valid), .table_ready(table_ready), .done(done),
        .pass(pass), .proto_err(proto_err), .lookup_cnt(lookup_cnt)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [31:0] actual(int sel);
        case (sel)
            SEL_COST: return 32'(Cost);
            SEL_TRDY: return 32'(table_ready);
            SEL_LRDY: return 32'(load_ready);
            SEL_DONE: return 32'(done);
            SEL_PASS: return 32'(pass);
            SEL_PERR: return 32'(proto_err);
            default:  return 32'(lookup_cnt);
        endcase
    endfunction

    // Monitor: mid-cycle, check every expectation due in the current cycle.
    always @(negedge CLK) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
                logic [31:0] a;
                a = actual(q[i].sel);
                n_vec++;
                if (a !== q[i].val) begin
                    n_err++;
                    $display("FAIL %s: got %0d, expected %0d (cycle %0d)", q[i].name, a, q[i].val, cyc);
                end
                q.delete(i);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic expect_at(int d, int sel, logic [31:0] v, string nm);
        exp_t e;
        e.cyc = cyc + d; e.sel = sel; e.val = v; e.name = nm;
        q.push_back(e);
    endtask

    task automatic do_reset();
        RST = 1'b1; load_valid = 1'b0; Valid = 1'b0; gold_we = 1'b0;
        step();
        RST = 1'b0;
    endtask

    // Full 64-beat load of value index%100; optionally pulse Valid once mid-load.
    task automatic load_all(input bit inject);
        for (int i = 0; i < N_ENT; i++) begin
            if (inject && i == 20) begin
                load_valid = 1'b0; Valid = 1'b1;
                expect_at(1, SEL_PERR, 1, "proto_err_set");
                expect_at(1, SEL_LRDY, 1, "stay_load");
                step();
                Valid = 1'b0;
            end
            load_valid = 1'b1;
            load_data  = cost_t'(i % 100);
            if (i == N_ENT - 2) expect_at(1, SEL_TRDY, 0, "trdy_before_last");
            if (i == N_ENT - 1) begin
                expect_at(1, SEL_TRDY, 1, "trdy_after_last");
                expect_at(1, SEL_LRDY, 0, "lrdy_after_last");
            end
            step();
        end
        load_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; load_valid = 1'b0; load_data = '0; gold_we = 1'b0;
        gold_min_cost = '0; gold_match_cnt = '0; W = '0; J = '0;
        MinCost = '0; MatchCount = '0; Valid = 1'b0;
        step();
        step();
        expect_at(0, SEL_LRDY, 1, "rst_load_ready");
        expect_at(0, SEL_TRDY, 0, "rst_table_ready");
        expect_at(0, SEL_DONE, 0, "rst_done");
        expect_at(0, SEL_PASS, 0, "rst_pass");
        expect_at(0, SEL_PERR, 0, "rst_proto_err");
        expect_at(0, SEL_LCNT, 0, "rst_lookup_cnt");
        expect_at(0, SEL_COST, 0, "rst_cost");
        RST = 1'b0;

        // Partial load then reset mid-load.
        for (int i = 0; i < 10; i++) begin
            load_valid = 1'b1; load_data = cost_t'(77);
            step();
        end
        do_reset();
        expect_at(0, SEL_TRDY, 0, "midrst_trdy");
        expect_at(0, SEL_LRDY, 1, "midrst_lrdy");
        load_all(1'b1);

        // SERVE lookups.
        W = 3; J = 5;
        expect_at(1, SEL_COST, 29, "cost_3_5");
        expect_at(1, SEL_LCNT, 1, "lcnt_first");
        expect_at(1, SEL_PERR, 1, "proto_err_sticky");
        step();
        W = 0; J = 0; expect_at(1, SEL_COST, 0, "cost_0_0_new"); step();
        W = 7; J = 7; expect_at(1, SEL_COST, 63, "cost_7_7"); step();
        W = 2; J = 1; expect_at(1, SEL_COST, 17, "cost_2_1");
        expect_at(1, SEL_LCNT, 4, "lcnt_plus3"); step();

        // load_valid in SERVE must not write the table.
        load_valid = 1'b1; load_data = cost_t'(127); W = 0; J = 0;
        expect_at(1, SEL_COST, 0, "serve_noload_e0"); step();
        load_valid = 1'b0; W = 0; J = 1;
        expect_at(1, SEL_COST, 1, "serve_noload_e1"); step();

        // Matching result.
        gold_we = 1'b1; gold_min_cost = 450; gold_match_cnt = 4;
        expect_at(1, SEL_DONE, 0, "done_before_valid"); step();
        gold_we = 1'b0;
        MinCost = 450; MatchCount = 4; Valid = 1'b1;
        expect_at(1, SEL_DONE, 1, "done_match");
        expect_at(1, SEL_PASS, 1, "pass_match");
        expect_at(1, SEL_LCNT, 8, "lcnt_at_capture"); step();
        Valid = 1'b0; step();
        MinCost = 0; MatchCount = 0; Valid = 1'b1; W = 7; J = 7;
        gold_we = 1'b1; gold_min_cost = 0; gold_match_cnt = 0;
        expect_at(1, SEL_PASS, 1, "pass_held");
        expect_at(1, SEL_COST, 63, "done_cost_track");
        expect_at(1, SEL_LCNT, 8, "lcnt_hold_done"); step();
        Valid = 1'b0; gold_we = 1'b0; step();

        // Mismatching MinCost.
        do_reset();
        expect_at(0, SEL_PERR, 0, "rst2_proto_err");
        expect_at(0, SEL_DONE, 0, "rst2_done");
        load_all(1'b0);
        gold_we = 1'b1; gold_min_cost = 450; gold_match_cnt = 4; step();
        gold_we = 1'b0;
        MinCost = 451; MatchCount = 4; Valid = 1'b1;
        expect_at(1, SEL_DONE, 1, "done_mismatch");
        expect_at(1, SEL_PASS, 0, "pass_mismatch"); step();
        Valid = 1'b0; step();

        // Same-edge golden write: compare uses the old golden values.
        do_reset();
        load_all(1'b0);
        gold_we = 1'b1; gold_min_cost = 450; gold_match_cnt = 4; step();
        gold_min_cost = 451; gold_match_cnt = 5;
        MinCost = 450; MatchCount = 4; Valid = 1'b1;
        expect_at(1, SEL_DONE, 1, "done_same_edge");
        expect_at(1, SEL_PASS, 1, "pass_old_golden"); step();
        Valid = 1'b0; gold_we = 1'b0;
        step();
        step();

        n_vec += q.size();
        n_err += q.size();
        if (q.size() != 0)
            $display("FAIL leftover: got %0d unchecked, expected 0", q.size());
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
